pass_switch_arbiter: RTL



---
 rtl/pass_switch_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/pass_switch_arbiter.sv
// Round-robin arbiter and break-before-make controller for one tranif1 pass switch.
// Define HOLD_LIMIT_EN to add the MAX_HOLD forced-release (preempt) logic.
module pass_switch_arbiter #(
    parameter int TURNAROUND_CYCLES = 2,
    parameter int MAX_HOLD          = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic req_l,
    input  logic req_r,
    output logic gnt_l,
    output logic gnt_r,
    output logic dir,
    output logic sw_en,
    output logic left_oe,
    output logic right_oe,
    output logic busy,
    output logic preempt
);

    // state  | meaning
    // IDLE   | all drivers off, switch open; arbitrate pending requests
    // SETUP  | owner driver enabled, dir set, switch still open
    // ACTIVE | switch conducting, owner granted
    // BREAK  | switch opened, owner driver still enabled
    // TURN   | all drivers off for TURNAROUND_CYCLES cycles
    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACTIVE,
        S_BREAK,
        S_TURN
    } state_t;

    localparam int TW = (TURNAROUND_CYCLES > 0) ? $clog2(TURNAROUND_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TURN_LOAD = (TURNAROUND_CYCLES > 0) ? TW'(TURNAROUND_CYCLES - 1) : '0;

    state_t        state, state_nxt;
    logic          owner, owner_nxt;          // 0 = left, 1 = right
    logic          last_served, last_nxt;
    logic [TW-1:0] turn_cnt, turn_nxt;
    logic          owner_req, other_req, force_brk;
    logic          gnt_l_nxt, gnt_r_nxt, dir_nxt, sw_en_nxt;
    logic          left_oe_nxt, right_oe_nxt, busy_nxt, preempt_nxt, drive_nxt;

    assign owner_req = owner ? req_r : req_l;
    assign other_req = owner ? req_l : req_r;

`ifdef HOLD_LIMIT_EN
    localparam int HW = $clog2(MAX_HOLD + 1);
    logic [HW-1:0] hold_cnt;

    // Loaded with 1 on ACTIVE entry so the count includes the current ACTIVE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
        end else if (state == S_SETUP) begin
            hold_cnt <= HW'(1);
        end else if (state == S_ACTIVE && hold_cnt != HW'(MAX_HOLD)) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

    assign force_brk = (state == S_ACTIVE) && (hold_cnt == HW'(MAX_HOLD)) && other_req;
`else
    assign force_brk = 1'b0;
`endif

    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner;
        last_nxt    = last_served;
        turn_nxt    = turn_cnt;
        preempt_nxt = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_l || req_r) begin
                    state_nxt = S_SETUP;
                    owner_nxt = (req_l && req_r) ? ~last_served : req_r;
                end
            end
            S_SETUP:  state_nxt = S_ACTIVE;
            S_ACTIVE: begin
                if (!owner_req) begin
                    state_nxt = S_BREAK;
                end else if (force_brk) begin
                    state_nxt   = S_BREAK;
                    preempt_nxt = 1'b1;
                end
            end
            S_BREAK: begin
                last_nxt = owner;
                if (TURNAROUND_CYCLES == 0) begin
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt = S_TURN;
                    turn_nxt  = TURN_LOAD;
                end
            end
            S_TURN: begin
                if (turn_cnt == '0) state_nxt = S_IDLE;
                else                turn_nxt  = turn_cnt - 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase

        // Outputs are decoded from the next state so the registers line up with it.
        drive_nxt    = (state_nxt == S_SETUP) || (state_nxt == S_ACTIVE) || (state_nxt == S_BREAK);
        sw_en_nxt    = (state_nxt == S_ACTIVE);
        gnt_l_nxt    = sw_en_nxt && !owner_nxt;
        gnt_r_nxt    = sw_en_nxt && owner_nxt;
        left_oe_nxt  = drive_nxt && !owner_nxt;
        right_oe_nxt = drive_nxt && owner_nxt;
        busy_nxt     = (state_nxt != S_IDLE);
        dir_nxt      = (state_nxt == S_SETUP) ? owner_nxt : dir;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            owner       <= 1'b0;
            last_served <= 1'b1;
            turn_cnt    <= '0;
            gnt_l       <= 1'b0;
            gnt_r       <= 1'b0;
            dir         <= 1'b0;
            sw_en       <= 1'b0;
            left_oe     <= 1'b0;
            right_oe    <= 1'b0;
            busy        <= 1'b0;
            preempt     <= 1'b0;
        end else begin
            state       <= state_nxt;
            owner       <= owner_nxt;
            last_served <= last_nxt;
            turn_cnt    <= turn_nxt;
            gnt_l       <= gnt_l_nxt;
            gnt_r       <= gnt_r_nxt;
            dir         <= dir_nxt;
            sw_en       <= sw_en_nxt;
            left_oe     <= left_oe_nxt;
            right_oe    <= right_oe_nxt;
            busy        <= busy_nxt;
            preempt     <= preempt_nxt;
        end
    end

endmodule
